// File: rtl/debug_uart_tx_if.sv
// Bundle between the CPU debug ports and the debug UART transmitter.
// master: drives start and the seven debug bytes; slave: drives tx, busy and frame_done.
interface debug_uart_tx_if;
  logic       start;
  logic [7:0] debug_port1;
  logic [7:0] debug_port2;
  logic [7:0] debug_port3;
  logic [7:0] debug_port4;
  logic [7:0] debug_port5;
  logic [7:0] debug_port6;
  logic [7:0] debug_port7;
  logic       tx;
  logic       busy;
  logic       frame_done;

  modport master (
    output start,
    output debug_port1, debug_port2, debug_port3,
    output debug_port4, debug_port5, debug_port6,
    output debug_port7,
    input  tx, busy, frame_done
  );

  modport slave (
    input  start,
    input  debug_port1, debug_port2, debug_port3,
    input  debug_port4, debug_port5, debug_port6,
    input  debug_port7,
    output tx, busy, frame_done
  );
endinterface

// File: rtl/debug_uart_tx.sv
// Debug UART transmitter: snapshots seven debug bytes and sends an 8N1 frame
// (sync, port1..port7, xor checksum). Ports: clk, reset (sync, high), bus (slave).
module debug_uart_tx #(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic          clk,
  input  logic          reset,
  debug_uart_tx_if.slave bus
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [3:0]      byte_q, byte_d;
  logic [6:0][7:0] snap_q, snap_d;
  logic [7:0]      chk_q, chk_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            last;
  logic [7:0]      cur_byte;

  assign last = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      snap_q  <= '0;
      chk_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      snap_q  <= snap_d;
      chk_q   <= chk_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    snap_d  = snap_q;
    chk_d   = chk_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          snap_d = {bus.debug_port7, bus.debug_port6,
                    bus.debug_port5, bus.debug_port4,
                    bus.debug_port3, bus.debug_port2,
                    bus.debug_port1};
          chk_d  = bus.debug_port1 ^ bus.debug_port2 ^
                   bus.debug_port3 ^ bus.debug_port4 ^
                   bus.debug_port5 ^ bus.debug_port6 ^
                   bus.debug_port7;
          cnt_d   = '0;
          bit_d   = '0;
          byte_d  = '0;
          busy_d  = 1'b1;
          state_d = START_BIT;
        end
      end
      START_BIT: begin
        if (last) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA_BITS;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA_BITS: begin
        if (last) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP_BIT;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP_BIT: begin
        if (last) begin
          cnt_d = '0;
          if (byte_q == 4'd8) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            byte_d  = byte_q + 4'd1;
            state_d = START_BIT;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Byte selected by the next byte index so tx can be registered
  // one cycle ahead of the bit it represents.
  always_comb begin
    cur_byte = SYNC_BYTE;
    case (byte_d)
      4'd1:    cur_byte = snap_q[0];
      4'd2:    cur_byte = snap_q[1];
      4'd3:    cur_byte = snap_q[2];
      4'd4:    cur_byte = snap_q[3];
      4'd5:    cur_byte = snap_q[4];
      4'd6:    cur_byte = snap_q[5];
      4'd7:    cur_byte = snap_q[6];
      4'd8:    cur_byte = chk_q;
      default: cur_byte = SYNC_BYTE;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START_BIT: tx_d = 1'b0;
      DATA_BITS: tx_d = cur_byte[bit_d];
      default:   tx_d = 1'b1;
    endcase
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_debug_uart_tx.sv
// Directed bench for debug_uart_tx with CLKS_PER_BIT=4.
// Drives the master side of the interface and decodes the tx line.
module tb_debug_uart_tx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  debug_uart_tx_if bus ();

  debug_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ports(input logic [7:0] a, b, c, d,
                           input logic [7:0] e, f, g);
    bus.debug_port1 = a;
    bus.debug_port2 = b;
    bus.debug_port3 = c;
    bus.debug_port4 = d;
    bus.debug_port5 = e;
    bus.debug_port6 = f;
    bus.debug_port7 = g;
  endtask

  task automatic set_all(input logic [7:0] v);
    set_ports(v, v, v, v, v, v, v);
  endtask

  task automatic idle_for(input string tag, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if ({bus.tx, bus.busy, bus.frame_done} !== 3'b100) bad++;
      step();
    end
    chk(tag, bad, 0);
  endtask

  // Entered at the sample point right after the accepting edge.
  // Returns at the sample point where frame_done must be high.
  task automatic capture(input string tag,
                         input logic [7:0] exp [9],
                         input bit hold,
                         input int chg_at,
                         input logic [7:0] chg_val,
                         input int restart_at);
    logic [359:0] bits;
    logic [7:0]   b;
    int           busy_n;
    int           early;
    busy_n = 0;
    early  = 0;
    for (int j = 0; j < 360; j++) begin
      bits[j] = bus.tx;
      if (bus.busy === 1'b1) busy_n++;
      if (bus.frame_done !== 1'b0) early++;
      if (!hold) bus.start = (j == restart_at);
      if (j == chg_at) set_all(chg_val);
      step();
    end
    chk({tag, " done"}, bus.frame_done, 1);
    chk({tag, " busy_end"}, bus.busy, 0);
    chk({tag, " tx_end"}, bus.tx, 1);
    chk({tag, " busy_len"}, busy_n, 360);
    chk({tag, " early_done"}, early, 0);
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < 8; i++) b[i] = bits[40*k + 4*i + 6];
      chk($sformatf("%s byte%0d", tag, k), b, exp[k]);
      chk($sformatf("%s framing%0d", tag, k),
          {bits[40*k + 2], bits[40*k + 38]}, 2'b01);
    end
  endtask

  initial begin
    logic [7:0] e [9];
    int bad;

    reset     = 1'b1;
    bus.start = 1'b0;
    set_all(8'h00);
    step();
    step();
    step();
    chk("reset state", {bus.tx, bus.busy, bus.frame_done}, 3'b100);
    reset = 1'b0;
    idle_for("idle after reset", 50);

    set_ports(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07);
    bus.start = 1'b1;
    step();
    chk("f1 tx start", bus.tx, 0);
    e = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04,
          8'h05, 8'h06, 8'h07, 8'h00};
    capture("f1", e, 1'b0, -1, 8'h00, -1);
    step();
    idle_for("f1 idle", 20);

    set_ports(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    bus.start = 1'b1;
    step();
    e = '{8'hA5, 8'hFF, 8'h00, 8'h00, 8'h00,
          8'h00, 8'h00, 8'h00, 8'hFF};
    capture("snap", e, 1'b0, 10, 8'h55, -1);
    step();
    idle_for("snap idle", 10);

    bus.start = 1'b1;
    step();
    e = '{8'hA5, 8'h55, 8'h55, 8'h55, 8'h55,
          8'h55, 8'h55, 8'h55, 8'h55};
    capture("ign", e, 1'b0, -1, 8'h00, 100);
    step();
    idle_for("ign single frame", 60);

    set_ports(8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02);
    bus.start = 1'b1;
    step();
    e = '{8'hA5, 8'h80, 8'h40, 8'h20, 8'h10,
          8'h08, 8'h04, 8'h02, 8'hFE};
    capture("b2b1", e, 1'b1, 300, 8'h3C, -1);
    step();
    chk("b2b gap tx", bus.tx, 0);
    chk("b2b gap busy", bus.busy, 1);
    e = '{8'hA5, 8'h3C, 8'h3C, 8'h3C, 8'h3C,
          8'h3C, 8'h3C, 8'h3C, 8'h3C};
    capture("b2b2", e, 1'b0, -1, 8'h00, -1);
    step();
    idle_for("b2b idle", 10);

    set_ports(8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int j = 0; j < 130; j++) step();
    chk("mid busy before reset", bus.busy, 1);
    reset = 1'b1;
    step();
    chk("mid reset tx", bus.tx, 1);
    chk("mid reset busy", bus.busy, 0);
    chk("mid reset done", bus.frame_done, 0);
    reset = 1'b0;
    bad = 0;
    for (int j = 0; j < 400; j++) begin
      if ({bus.tx, bus.busy, bus.frame_done} !== 3'b100) bad++;
      step();
    end
    chk("mid reset quiet", bad, 0);

    reset     = 1'b1;
    bus.start = 1'b1;
    step();
    reset     = 1'b0;
    bus.start = 1'b0;
    chk("reset beats start", {bus.tx, bus.busy}, 2'b10);
    idle_for("reset beats start idle", 10);

    bus.start = 1'b1;
    step();
    e = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78,
          8'h9A, 8'hBC, 8'hDE, 8'hF0};
    capture("post", e, 1'b0, -1, 8'h00, -1);
    step();
    idle_for("post idle", 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
